// File: rtl/occ_rom_responder.sv
// Memory-side responder for the accelerator's Occ read interface.
// Host-loaded table; each accepted request answers after LATENCY cycles with one valid pulse.
module occ_rom_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              busy_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic [15:0]       served_cnt_o
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("occ_rom_responder: LATENCY must be in 1..15");
  end

  localparam logic [3:0] CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [15:0]       served_q, served_d;
  logic              accept;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Table is deliberately outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[w_addr_i] <= w_data_i;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_addr_d = last_addr_q;
    rd_d        = rd_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    served_d    = served_q;
    accept      = 1'b0;

    unique case (state_q)
      StIdle: accept = ce_i;
      StBusy: begin
        if (cnt_q == 4'd0) begin
          data_d  = rd_q;
          valid_d = 1'b1;
          if (served_q != 16'hFFFF) served_d = served_q + 16'd1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Hold off while the requester still presents the address just served.
      StDone: begin
        if (!ce_i) state_d = StIdle;
        else if (addr_i != last_addr_q) accept = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      rd_d        = mem_q[addr_i];
      last_addr_d = addr_i;
      cnt_d       = CntInit;
      state_d     = StBusy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      last_addr_q <= '0;
      rd_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      served_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_addr_q <= last_addr_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      served_q    <= served_d;
    end
  end

  assign data_o       = data_q;
  assign data_valid_o = valid_q;
  assign busy_o       = (state_q == StBusy);
  assign served_cnt_o = served_q;

endmodule

// File: tb/tb_occ_rom_responder.sv
// Bench for occ_rom_responder: deadline-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_occ_rom_responder;

  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ce;
  logic [AW-1:0] addr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          busy_o;
  logic [15:0]   served_o;

  int n_cmp = 0;
  int n_bad = 0;

  occ_rom_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce_i         (ce),
    .addr_i       (addr),
    .data_o       (data_o),
    .data_valid_o (valid_o),
    .busy_o       (busy_o),
    .we_i         (we),
    .w_addr_i     (waddr),
    .w_data_i     (wdata),
    .served_cnt_o (served_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request accepted on edge k completes on edge k+LAT.
  logic [DW-1:0] m_mem [256];
  logic          m_inflight, m_hold, m_valid;
  int            m_due, edge_n = 0;
  logic [DW-1:0] m_flight, m_data;
  logic [AW-1:0] m_last;
  logic [15:0]   m_served;
  bit            load_req = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_inflight = 0; m_hold = 0; m_valid = 0; m_data = '0; m_last = '0; m_served = '0;
    end else begin
      m_valid = 0;
      if (load_req) m_served = 16'hFFFE;
      if (m_inflight) begin
        if (edge_n == m_due) begin
          m_valid = 1; m_data = m_flight; m_inflight = 0; m_hold = 1;
          if (m_served != 16'hFFFF) m_served = m_served + 16'd1;
        end
      end else if (ce && !(m_hold && addr == m_last)) begin
        m_flight = m_mem[addr]; m_due = edge_n + LAT; m_inflight = 1; m_last = addr; m_hold = 0;
      end else if (!ce) begin
        m_hold = 0;
      end
    end
    if (we) m_mem[waddr] = wdata;
    edge_n++;
    #1;
    check("valid", {31'd0, valid_o}, {31'd0, m_valid});
    check("busy", {31'd0, busy_o}, {31'd0, m_inflight});
    check("served", {16'd0, served_o}, {16'd0, m_served});
    check("data", data_o, m_data);
  end

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  // Starts and ends at a negedge.
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1; waddr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  task automatic wait_valid(input string name, input int exp_n);
    int n = 0;
    bit got = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      n++;
      if (valid_o) begin got = 1; break; end
    end
    check({name, "_seen"}, {31'd0, got}, 32'd1);
    check({name, "_lat"}, n, exp_n);
  endtask

  initial begin
    rst_n = 0; ce = 0; addr = '0; we = 0; waddr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    sample();
    check("rst_data", data_o, 32'h0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_served", {16'd0, served_o}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Basic request, LATENCY=2
    write_word(8'h10, 32'hDEADBEEF);
    ce = 1; addr = 8'h10;
    sample(); check("t1_busy0", {31'd0, busy_o}, 32'd1);
    sample(); check("t1_busy1", {31'd0, busy_o}, 32'd1);
    check("t1_novalid", {31'd0, valid_o}, 32'd0);
    sample();
    check("t1_valid", {31'd0, valid_o}, 32'd1);
    check("t1_data", data_o, 32'hDEADBEEF);
    check("t1_served", {16'd0, served_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t1_hold_valid", {31'd0, valid_o}, 32'd0);
      check("t1_hold_served", {16'd0, served_o}, 32'd1);
    end
    @(negedge clk); ce = 0;
    @(negedge clk); ce = 1;
    wait_valid("t1_again", 3);
    check("t1_again_data", data_o, 32'hDEADBEEF);
    check("t1_again_served", {16'd0, served_o}, 32'd2);

    // Back-to-back by changing address in the done cycle
    @(negedge clk); ce = 0;
    @(negedge clk);
    write_word(8'h01, 32'h11);
    write_word(8'h02, 32'h22);
    ce = 1; addr = 8'h01;
    wait_valid("t3_a", 3);
    check("t3_a_data", data_o, 32'h11);
    @(negedge clk); addr = 8'h02;
    wait_valid("t3_b", 3);
    check("t3_b_data", data_o, 32'h22);

    // Writes on the accepting edge and mid-flight do not disturb the read
    @(negedge clk); ce = 0;
    @(negedge clk);
    write_word(8'h05, 32'hAAAA);
    ce = 1; addr = 8'h05; we = 1; waddr = 8'h05; wdata = 32'hBBBB;
    @(negedge clk);
    @(negedge clk); we = 0;
    wait_valid("t4_a", 1);
    check("t4_a_data", data_o, 32'hAAAA);
    @(negedge clk); ce = 0;
    @(negedge clk); ce = 1;
    wait_valid("t4_b", 3);
    check("t4_b_data", data_o, 32'hBBBB);

    // Reset mid-flight
    @(negedge clk); ce = 0;
    @(negedge clk); ce = 1; addr = 8'h10;
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; ce = 0;
    sample();
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    check("t5_data", data_o, 32'h0);
    check("t5_served", {16'd0, served_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t5_novalid", {31'd0, valid_o}, 32'd0);
    end
    @(negedge clk); ce = 1; addr = 8'h02;
    wait_valid("t5_next", 3);
    check("t5_next_data", data_o, 32'h22);
    check("t5_next_served", {16'd0, served_o}, 32'd1);

    // Saturation
    @(negedge clk); ce = 0;
    force dut.served_q = 16'hFFFE;
    load_req = 1;
    @(negedge clk);
    release dut.served_q;
    load_req = 0;
    ce = 1; addr = 8'h01;
    wait_valid("t6_a", 3);
    check("t6_a_served", {16'd0, served_o}, 32'h0000FFFF);
    @(negedge clk); ce = 0;
    @(negedge clk); ce = 1;
    wait_valid("t6_b", 3);
    check("t6_b_served", {16'd0, served_o}, 32'h0000FFFF);
    check("t6_b_data", data_o, 32'h11);
    sample();
    check("t6_pulse", {31'd0, valid_o}, 32'd0);

    @(negedge clk); ce = 0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

endmodule
